// File: rtl/misc_monitor_pkg.sv
// ============================================================================
// Module      : misc_monitor_pkg
// Description : Shared constants and types for the instruction-fetch monitor.
//               Holds the word-alignment pattern, the sequential fetch stride,
//               the branch-history depth and pointer width, and the fetch
//               classification enum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package misc_monitor_pkg;

  // Low address bits of a properly word-aligned fetch
  localparam logic [1:0] c_WORD_ALIGN = 2'b00;

  // Byte stride between two sequential instruction fetches
  localparam int c_SEQ_INC = 4;

  // Branch-history ring buffer geometry
  localparam int c_HIST_DEPTH = 8;
  localparam int c_HIST_PTR_W = 3;

  // Classification of the current cycle's fetch activity
  typedef enum logic [1:0] {
    FETCH_IDLE   = 2'd0,
    FETCH_FIRST  = 2'd1,
    FETCH_SEQ    = 2'd2,
    FETCH_BRANCH = 2'd3
  } fetch_kind_e;

endpackage

`default_nettype wire

// File: rtl/misc_sat_counter.sv
// ============================================================================
// Module      : misc_sat_counter
// Description : Saturating up-counter with increment enable, synchronous
//               load and asynchronous active-low clear. Load has priority
//               over increment; the count holds once it reaches MAX.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module misc_sat_counter #(
  parameter int           W   = 32,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise step up unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/misc_monitor.sv
// ============================================================================
// Module      : misc_monitor
// Description : Passive monitor on the core's ROM fetch port. Counts fetches
//               and branches, records the last fetch address, flags
//               misaligned and out-of-range fetches (sticky, with the first
//               offending address captured) and detects a branch-to-self
//               halt loop. All outputs are registered (latency 1).
//               Optional build macro MISC_BRANCH_HIST_EN adds an 8-entry
//               ring buffer of branch targets readable through hist_idx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module misc_monitor
  import misc_monitor_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int ROM_BYTES = 8192,
  parameter int CNT_W     = 32,
  parameter int HALT_CNT  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rom_en,
  input  logic [ADDR_W-1:0]       rom_addr,
`ifdef MISC_BRANCH_HIST_EN
  input  logic [c_HIST_PTR_W-1:0] hist_idx,
  output logic [ADDR_W-1:0]       hist_addr,
`endif
  output logic [CNT_W-1:0]        fetch_cnt,
  output logic [CNT_W-1:0]        branch_cnt,
  output logic [ADDR_W-1:0]       last_addr,
  output logic                    halt,
  output logic                    misalign_err,
  output logic                    range_err,
  output logic [ADDR_W-1:0]       err_addr
);

  localparam int                LOOP_W      = $clog2(HALT_CNT + 1);
  localparam logic [LOOP_W-1:0] c_LOOP_MAX  = LOOP_W'(HALT_CNT);
  localparam logic [LOOP_W-1:0] c_LOOP_PRE  = LOOP_W'(HALT_CNT - 1);
  localparam logic [ADDR_W:0]   c_ROM_LIMIT = (ADDR_W + 1)'(ROM_BYTES);

  // Architectural state
  logic              seen_q,      seen_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [ADDR_W-1:0] target_q,    target_d;
  logic              halt_q,      halt_d;
  logic              misalign_q,  misalign_d;
  logic              range_q,     range_d;
  logic [ADDR_W-1:0] err_addr_q,  err_addr_d;

  // Combinational decode of the current fetch
  fetch_kind_e       w_kind;
  logic [ADDR_W-1:0] w_seq_addr;
  logic [ADDR_W:0]   w_end_addr;
  logic              w_branch;
  logic              w_hit;
  logic              w_misalign;
  logic              w_range;
  logic [LOOP_W-1:0] w_loop_cnt;

  // Sequential address wraps naturally at 2^ADDR_W
  assign w_seq_addr = last_addr_q + ADDR_W'(c_SEQ_INC);
  // One extra bit so rom_addr+3 cannot overflow the range comparison
  assign w_end_addr = {1'b0, rom_addr} + (ADDR_W + 1)'(3);

  // Classify the fetch: first after reset, sequential or branch
  always_comb begin
    w_kind = FETCH_IDLE;
    if (rom_en) begin
      if (!seen_q) begin
        w_kind = FETCH_FIRST;
      end else if (rom_addr == w_seq_addr) begin
        w_kind = FETCH_SEQ;
      end else begin
        w_kind = FETCH_BRANCH;
      end
    end
  end

  assign w_branch   = (w_kind == FETCH_BRANCH);
  assign w_hit      = w_branch && (rom_addr == target_q);
  assign w_misalign = rom_en && (rom_addr[1:0] != c_WORD_ALIGN);
  assign w_range    = rom_en && (w_end_addr >= c_ROM_LIMIT);

  // Next-state for address tracking, halt and sticky error capture
  always_comb begin
    seen_d      = seen_q;
    last_addr_d = last_addr_q;
    target_d    = target_q;
    halt_d      = halt_q;
    misalign_d  = misalign_q;
    range_d     = range_q;
    err_addr_d  = err_addr_q;

    if (rom_en) begin
      seen_d      = 1'b1;
      last_addr_d = rom_addr;
    end

    if (w_branch) begin
      if (w_hit) begin
        // Loop count after this hit reaches (or stays at) the threshold
        halt_d = (w_loop_cnt >= c_LOOP_PRE);
      end else begin
        // New target restarts the loop count at 1, which is below threshold
        target_d = rom_addr;
        halt_d   = 1'b0;
      end
    end

    if (w_misalign) begin
      misalign_d = 1'b1;
    end
    if (w_range) begin
      range_d = 1'b1;
    end
    // Only the very first offending fetch is recorded
    if ((w_misalign || w_range) && !misalign_q && !range_q) begin
      err_addr_d = rom_addr;
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q      <= 1'b0;
      last_addr_q <= '0;
      target_q    <= '0;
      halt_q      <= 1'b0;
      misalign_q  <= 1'b0;
      range_q     <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      seen_q      <= seen_d;
      last_addr_q <= last_addr_d;
      target_q    <= target_d;
      halt_q      <= halt_d;
      misalign_q  <= misalign_d;
      range_q     <= range_d;
      err_addr_q  <= err_addr_d;
    end
  end

  misc_sat_counter #(
    .W   (CNT_W)
  ) u_fetch_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (rom_en),
    .load_i     (1'b0),
    .load_val_i ('0),
    .cnt_o      (fetch_cnt)
  );

  misc_sat_counter #(
    .W   (CNT_W)
  ) u_branch_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (w_branch),
    .load_i     (1'b0),
    .load_val_i ('0),
    .cnt_o      (branch_cnt)
  );

  // Hits on the same target climb toward HALT_CNT; a new target reloads 1
  misc_sat_counter #(
    .W   (LOOP_W),
    .MAX (c_LOOP_MAX)
  ) u_loop_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (w_hit),
    .load_i     (w_branch && !w_hit),
    .load_val_i (LOOP_W'(1)),
    .cnt_o      (w_loop_cnt)
  );

`ifdef MISC_BRANCH_HIST_EN
  logic [ADDR_W-1:0]       hist_q [c_HIST_DEPTH];
  logic [c_HIST_PTR_W-1:0] wr_ptr_q;
  logic [c_HIST_PTR_W-1:0] w_rd_ptr;

  // Ring buffer of branch targets; pointer wraps 7->0 by width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < c_HIST_DEPTH; i++) begin
        hist_q[i] <= '0;
      end
    end else if (w_branch) begin
      hist_q[wr_ptr_q] <= rom_addr;
      wr_ptr_q         <= wr_ptr_q + c_HIST_PTR_W'(1);
    end
  end

  // hist_idx=0 selects the most recently written entry
  assign w_rd_ptr  = wr_ptr_q - c_HIST_PTR_W'(1) - hist_idx;
  assign hist_addr = hist_q[w_rd_ptr];
`endif

  assign last_addr    = last_addr_q;
  assign halt         = halt_q;
  assign misalign_err = misalign_q;
  assign range_err    = range_q;
  assign err_addr     = err_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_misc_monitor.sv
// ============================================================================
// Module      : tb_misc_monitor
// Description : Self-checking bench for misc_monitor. A constant table covers
//               counting, wrap, error flags and range boundaries; hand
//               sequences cover the halt loop, mid-run reset and (when
//               MISC_BRANCH_HIST_EN is defined) the branch-history buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_misc_monitor;

  localparam int ADDR_W    = 32;
  localparam int ROM_BYTES = 8192;
  localparam int CNT_W     = 32;
  localparam int HALT_CNT  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rom_en = 1'b0;
  logic [ADDR_W-1:0] rom_addr = '0;
  logic [CNT_W-1:0]  fetch_cnt;
  logic [CNT_W-1:0]  branch_cnt;
  logic [ADDR_W-1:0] last_addr;
  logic              halt;
  logic              misalign_err;
  logic              range_err;
  logic [ADDR_W-1:0] err_addr;
`ifdef MISC_BRANCH_HIST_EN
  logic [2:0]        hist_idx = '0;
  logic [ADDR_W-1:0] hist_addr;
`endif

  misc_monitor #(
    .ADDR_W    (ADDR_W),
    .ROM_BYTES (ROM_BYTES),
    .CNT_W     (CNT_W),
    .HALT_CNT  (HALT_CNT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
`ifdef MISC_BRANCH_HIST_EN
    .hist_idx     (hist_idx),
    .hist_addr    (hist_addr),
`endif
    .fetch_cnt    (fetch_cnt),
    .branch_cnt   (branch_cnt),
    .last_addr    (last_addr),
    .halt         (halt),
    .misalign_err (misalign_err),
    .range_err    (range_err),
    .err_addr     (err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fcnt;
    logic [31:0] bcnt;
    logic [31:0] last;
    logic        halt;
    logic        mis;
    logic        rng;
    logic [31:0] err;
  } obs_t;

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] addr;
    obs_t        exp;
  } vec_t;

  vec_t tbl[$];
  obs_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state
  logic [31:0] m_fcnt, m_bcnt, m_last, m_target, m_err;
  int          m_loop;
  logic        m_seen, m_mis, m_rng;

  function automatic obs_t mk(input logic [31:0] f, input logic [31:0] b, input logic [31:0] l,
                              input logic h, input logic m, input logic r, input logic [31:0] e);
    obs_t o;
    o.fcnt = f; o.bcnt = b; o.last = l; o.halt = h; o.mis = m; o.rng = r; o.err = e;
    return o;
  endfunction

  task automatic add(input logic rst, input logic en, input logic [31:0] addr, input obs_t exp);
    vec_t v;
    v.rst = rst; v.en = en; v.addr = addr; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic m_reset();
    m_fcnt = '0; m_bcnt = '0; m_last = '0; m_target = '0; m_err = '0;
    m_loop = 0; m_seen = 1'b0; m_mis = 1'b0; m_rng = 1'b0;
  endtask

  function automatic obs_t m_obs();
    return mk(m_fcnt, m_bcnt, m_last, (m_loop == HALT_CNT), m_mis, m_rng, m_err);
  endfunction

  task automatic m_step(input logic en, input logic [31:0] addr);
    logic bad_al, bad_rg;
    if (en) begin
      if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
      if (m_seen && (addr != m_last + 32'd4)) begin
        if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 1;
        if (addr == m_target) begin
          if (m_loop < HALT_CNT) m_loop = m_loop + 1;
        end else begin
          m_target = addr;
          m_loop   = 1;
        end
      end
      bad_al = (addr[1:0] != 2'b00);
      bad_rg = ((64'(addr) + 64'd3) >= 64'(ROM_BYTES));
      if ((bad_al || bad_rg) && !m_mis && !m_rng) m_err = addr;
      if (bad_al) m_mis = 1'b1;
      if (bad_rg) m_rng = 1'b1;
      m_seen = 1'b1;
      m_last = addr;
    end
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs
  task automatic check(input string name);
    obs_t e;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty, no expected value", name);
    end else begin
      e = sb_q.pop_front();
      if (fetch_cnt !== e.fcnt || branch_cnt !== e.bcnt || last_addr !== e.last ||
          halt !== e.halt || misalign_err !== e.mis || range_err !== e.rng || err_addr !== e.err) begin
        n_bad++;
        $display("FAIL %s: got f=%0d b=%0d last=%h h=%b m=%b r=%b err=%h, want f=%0d b=%0d last=%h h=%b m=%b r=%b err=%h",
                 name, fetch_cnt, branch_cnt, last_addr, halt, misalign_err, range_err, err_addr,
                 e.fcnt, e.bcnt, e.last, e.halt, e.mis, e.rng, e.err);
      end
    end
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic do_reset(input obs_t exp, input string name);
    @(negedge clk);
    rom_en = 1'b0;
    rst_n  = 1'b0;
    m_reset();
    sb_q.push_back(exp);
    #1;
    check(name);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle of stimulus driven from the model
  task automatic drive(input logic en, input logic [31:0] addr, input string name);
    @(negedge clk);
    rom_en   = en;
    rom_addr = addr;
    m_step(en, addr);
    sb_q.push_back(m_obs());
    @(posedge clk);
    #1;
    check(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0);
    m_reset();

    // rst, en, addr | fetch, branch, last, halt, mis, rng, err
    add(1, 0, 32'h0,         z);
    add(0, 1, 32'h0,         mk(1,  0, 32'h0,         0, 0, 0, 0));
    add(0, 1, 32'h4,         mk(2,  0, 32'h4,         0, 0, 0, 0));
    add(0, 1, 32'h8,         mk(3,  0, 32'h8,         0, 0, 0, 0));
    add(0, 0, 32'h123,       mk(3,  0, 32'h8,         0, 0, 0, 0));
    add(0, 1, 32'hC,         mk(4,  0, 32'hC,         0, 0, 0, 0));
    add(0, 1, 32'h10,        mk(5,  0, 32'h10,        0, 0, 0, 0));
    add(0, 1, 32'h100,       mk(6,  1, 32'h100,       0, 0, 0, 0));
    add(0, 1, 32'h100,       mk(7,  2, 32'h100,       0, 0, 0, 0));
    add(0, 1, 32'h6,         mk(8,  3, 32'h6,         0, 1, 0, 32'h6));
    add(0, 1, 32'h2000,      mk(9,  4, 32'h2000,      0, 1, 1, 32'h6));
    add(0, 1, 32'hFFFF_FFFC, mk(10, 5, 32'hFFFF_FFFC, 0, 1, 1, 32'h6));
    add(0, 1, 32'h0,         mk(11, 5, 32'h0,         0, 1, 1, 32'h6));
    add(1, 0, 32'h0,         z);
    add(0, 1, 32'h1FFC,      mk(1,  0, 32'h1FFC,      0, 0, 0, 0));
    add(0, 1, 32'h1FFD,      mk(2,  1, 32'h1FFD,      0, 1, 1, 32'h1FFD));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) begin
        do_reset(tbl[i].exp, $sformatf("tbl%0d_reset", i));
      end else begin
        @(negedge clk);
        rom_en   = tbl[i].en;
        rom_addr = tbl[i].addr;
        sb_q.push_back(tbl[i].exp);
        @(posedge clk);
        #1;
        check($sformatf("tbl%0d", i));
      end
    end

    // Halt loop: X, X+4, X+8 repeated; halt after the 16th hit on X
    do_reset(z, "halt_reset");
    drive(1'b1, 32'h0, "halt_first");
    for (int it = 1; it <= HALT_CNT + 1; it++) begin
      drive(1'b1, 32'h200, $sformatf("halt_it%0d_x", it));
      drive(1'b1, 32'h204, $sformatf("halt_it%0d_x4", it));
      drive(1'b1, 32'h208, $sformatf("halt_it%0d_x8", it));
    end
    drive(1'b1, 32'h300, "halt_clear");

    // Mid-run asynchronous reset, then first-fetch semantics again
    do_reset(z, "mid_reset_pre");
    drive(1'b1, 32'h0,   "mid_f1");
    drive(1'b1, 32'h4,   "mid_f2");
    drive(1'b1, 32'h8,   "mid_f3");
    drive(1'b1, 32'h100, "mid_f4");
    drive(1'b1, 32'h104, "mid_f5");
    #2;
    rst_n  = 1'b0;
    rom_en = 1'b0;
    m_reset();
    sb_q.push_back(z);
    #1;
    check("mid_reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h500, "post_reset_first");
    drive(1'b1, 32'h500, "post_reset_repeat");
    drive(1'b0, 32'h0,   "post_reset_idle");

`ifdef MISC_BRANCH_HIST_EN
    do_reset(z, "hist_reset");
    drive(1'b1, 32'h0, "hist_first");
    for (int k = 1; k <= 9; k++) begin
      drive(1'b1, 32'(k) << 8, $sformatf("hist_br%0d", k));
    end
    @(negedge clk);
    rom_en = 1'b0;
    for (int j = 0; j < 8; j++) begin
      logic [31:0] want;
      hist_idx = 3'(j);
      want     = 32'(9 - j) << 8;
      #1;
      n_vec++;
      if (hist_addr !== want) begin
        n_bad++;
        $display("FAIL hist_idx%0d: got %h, want %h", j, hist_addr, want);
      end
    end
`endif

    @(negedge clk);
    rom_en = 1'b0;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
